// File: rtl/uart_tx_engine.sv
// uart_tx_engine: UART transmit path (frame FSM, bit-rate prescaler, serializer,
// parity generator, output mux) with back-to-back frame support.
// Ports:
//   clk        - single clock, rising edge
//   rst        - synchronous reset, active low
//   P_DATA     - parallel data, latched on accept
//   Data_valid - request to send P_DATA
//   PAR_EN     - append parity bit (latched on accept)
//   PAR_TYP    - 0 = even, 1 = odd parity (latched on accept)
//   TX_OUT     - registered serial line, idle high
//   busy       - frame in progress
//   tx_done    - one-cycle pulse in the last cycle of each frame
module uart_tx_engine #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int unsigned PW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  // Data range (>=5) always dominates the stop-bit range (<=2).
  localparam int unsigned BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST  = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] STOP_LAST  = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state, nxt_state;
  logic [PW-1:0]         presc, nxt_presc;
  logic [BW-1:0]         bit_cnt, nxt_bit;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  par_en_q, par_typ_q;

  logic tick_c, ready_c, accept_c, nxt_last_c, nxt_tx_c;

  // Bit boundary and accept qualification from current state
  assign tick_c   = (presc == PRESC_LAST);
  assign ready_c  = (state == IDLE) ||
                    ((state == STOP) && tick_c && (bit_cnt == STOP_LAST));
  assign accept_c = Data_valid && ready_c;

  // Next-state and counter logic
  always_comb begin
    nxt_state = state;
    nxt_presc = tick_c ? '0 : presc + PW'(1);
    nxt_bit   = bit_cnt;
    case (state)
      IDLE: begin
        nxt_presc = '0;
        nxt_bit   = '0;
        if (accept_c) nxt_state = START;
      end
      START: begin
        if (tick_c) begin
          nxt_state = DATA;
          nxt_bit   = '0;
        end
      end
      DATA: begin
        if (tick_c) begin
          if (bit_cnt == DATA_LAST) begin
            nxt_state = par_en_q ? PARITY : STOP;
            nxt_bit   = '0;
          end else begin
            nxt_bit = bit_cnt + BW'(1);
          end
        end
      end
      PARITY: begin
        if (tick_c) begin
          nxt_state = STOP;
          nxt_bit   = '0;
        end
      end
      STOP: begin
        if (tick_c) begin
          if (bit_cnt == STOP_LAST) begin
            nxt_state = accept_c ? START : IDLE;
            nxt_bit   = '0;
          end else begin
            nxt_bit = bit_cnt + BW'(1);
          end
        end
      end
      default: begin
        nxt_state = IDLE;
        nxt_presc = '0;
        nxt_bit   = '0;
      end
    endcase
  end

  // Output mux evaluated on next state so TX_OUT/tx_done land in the same cycle as the state
  always_comb begin
    nxt_tx_c = 1'b1;
    case (nxt_state)
      START:   nxt_tx_c = 1'b0;
      DATA:    nxt_tx_c = data_q[nxt_bit];
      PARITY:  nxt_tx_c = (^data_q) ^ par_typ_q;
      default: nxt_tx_c = 1'b1;
    endcase
  end

  assign nxt_last_c = (nxt_state == STOP) && (nxt_presc == PRESC_LAST) &&
                      (nxt_bit == STOP_LAST);

  // State, counters, frame register and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      presc     <= '0;
      bit_cnt   <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      TX_OUT    <= 1'b1;
      busy      <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      state   <= nxt_state;
      presc   <= nxt_presc;
      bit_cnt <= nxt_bit;
      if (accept_c) begin
        data_q    <= P_DATA;
        par_en_q  <= PAR_EN;
        par_typ_q <= PAR_TYP;
      end
      TX_OUT  <= nxt_tx_c;
      busy    <= (nxt_state != IDLE);
      tx_done <= nxt_last_c;
    end
  end

endmodule
